// File: rtl/alu_muldiv_seq.sv
// Multi-cycle MULU/MULHU/DIVU/REMU sequencer that borrows the shared add/sub ALU, one step per cycle.
// Define MULDIV_SIGNED_EN to make op_signed select signed MUL/MULH/DIV/REM.
module alu_muldiv_seq #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic         op_signed,
    input  logic [N-1:0] src_a,
    input  logic [N-1:0] src_b,
    output logic         alu_own,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [2:0]   alu_ctrl,
    input  logic [N-1:0] alu_sum,
    input  logic         alu_cout,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    state_t state, state_nx;

    // acc doubles as the divide remainder, mq as the dividend/quotient, opb as multiplicand/divisor
    logic [N-1:0]  acc, mq, opb, result_nx;
    logic [N-1:0]  acc_nx, mq_nx, opb_nx;
    logic [1:0]    op_r, op_nx;
    logic          neg_r, neg_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          sgn_a, sgn_b;
    logic [N-1:0]  mag_a, mag_b, rem_s;
    logic          hi, is_div, last, div_zero;

    function automatic logic [N-1:0] negate(input logic [N-1:0] x);
        return ~x + {{(N-1){1'b0}}, 1'b1};
    endfunction

    // High word of a negated 2N-bit product: the +1 carries in only when the low word is zero
    function automatic logic [N-1:0] negate_hi(input logic [N-1:0] x, input logic lo_zero);
        return ~x + {{(N-1){1'b0}}, lo_zero};
    endfunction

`ifdef MULDIV_SIGNED_EN
    assign sgn_a = op_signed & src_a[N-1];
    assign sgn_b = op_signed & src_b[N-1];
`else
    logic unused_op_signed;
    assign unused_op_signed = op_signed;
    assign sgn_a = 1'b0;
    assign sgn_b = 1'b0;
`endif

    assign mag_a    = sgn_a ? negate(src_a) : src_a;
    assign mag_b    = sgn_b ? negate(src_b) : src_b;
    assign is_div   = op_r[1];
    assign hi       = acc[N-1];
    assign rem_s    = {acc[N-2:0], mq[N-1]};
    assign last     = (cnt == CW'(N - 1));
    assign div_zero = op[1] && (src_b == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = div_zero ? DONE : RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        alu_own  = 1'b0;
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = 3'b000;
        busy     = (state != IDLE);
        done     = (state == DONE);
        if (state == RUN) begin
            alu_own = 1'b1;
            alu_b   = opb;
            if (is_div) begin
                alu_a    = rem_s;
                alu_ctrl = 3'b001;
            end else begin
                alu_a = acc;
            end
        end
    end

    always_comb begin
        acc_nx = acc;
        mq_nx  = mq;
        opb_nx = opb;
        op_nx  = op_r;
        neg_nx = neg_r;
        cnt_nx = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    op_nx  = op;
                    cnt_nx = '0;
                    acc_nx = '0;
                    if (div_zero) begin
                        // Quotient all ones, remainder is the raw dividend, no sign fix-up
                        acc_nx = src_a;
                        mq_nx  = '1;
                        opb_nx = '0;
                        neg_nx = 1'b0;
                    end else if (op[1]) begin
                        mq_nx  = mag_a;
                        opb_nx = mag_b;
                        neg_nx = op[0] ? sgn_a : (sgn_a ^ sgn_b);
                    end else begin
                        mq_nx  = mag_b;
                        opb_nx = mag_a;
                        neg_nx = sgn_a ^ sgn_b;
                    end
                end
            end
            RUN: begin
                cnt_nx = cnt + CW'(1);
                if (is_div) begin
                    // hi set means the shifted remainder already exceeds any N-bit divisor
                    if (hi | alu_cout) begin
                        acc_nx = alu_sum;
                        mq_nx  = {mq[N-2:0], 1'b1};
                    end else begin
                        acc_nx = rem_s;
                        mq_nx  = {mq[N-2:0], 1'b0};
                    end
                end else if (mq[0]) begin
                    acc_nx = {alu_cout, alu_sum[N-1:1]};
                    mq_nx  = {alu_sum[0], mq[N-1:1]};
                end else begin
                    acc_nx = {1'b0, acc[N-1:1]};
                    mq_nx  = {acc[0], mq[N-1:1]};
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        case (op_nx)
            2'b00:   result_nx = neg_nx ? negate(mq_nx) : mq_nx;
            2'b01:   result_nx = neg_nx ? negate_hi(acc_nx, mq_nx == '0) : acc_nx;
            2'b10:   result_nx = neg_nx ? negate(mq_nx) : mq_nx;
            default: result_nx = neg_nx ? negate(acc_nx) : acc_nx;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            mq     <= '0;
            opb    <= '0;
            op_r   <= '0;
            neg_r  <= 1'b0;
            cnt    <= '0;
            result <= '0;
        end else begin
            acc   <= acc_nx;
            mq    <= mq_nx;
            opb   <= opb_nx;
            op_r  <= op_nx;
            neg_r <= neg_nx;
            cnt   <= cnt_nx;
            if (state_nx == DONE) result <= result_nx;
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq with a behavioural model of the shared add/sub ALU.
// Signed expectations are used only when MULDIV_SIGNED_EN is defined.
module tb_alu_muldiv_seq;
    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset, start, op_signed;
    logic [1:0]   op;
    logic [N-1:0] src_a, src_b;
    logic         alu_own, alu_cout, busy, done;
    logic [N-1:0] alu_a, alu_b, alu_sum, result;
    logic [2:0]   alu_ctrl;

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt = 0;
    int own_cnt  = 0;

    typedef struct {
        logic [N-1:0] res;
        int           edge_no;
        int           own;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    alu_muldiv_seq #(.N(N)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .op_signed(op_signed),
        .src_a(src_a), .src_b(src_b), .alu_own(alu_own), .alu_a(alu_a), .alu_b(alu_b),
        .alu_ctrl(alu_ctrl), .alu_sum(alu_sum), .alu_cout(alu_cout), .busy(busy),
        .done(done), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Shared ALU: add, or subtract as A + ~B + 1 so carry-out means A >= B
    always_comb begin
        if (alu_ctrl == 3'b001) {alu_cout, alu_sum} = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        else                    {alu_cout, alu_sum} = {1'b0, alu_a} + {1'b0, alu_b};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [N-1:0] model(input logic [1:0] o, input logic sg,
                                           input logic [N-1:0] a, input logic [N-1:0] b);
        logic [63:0]         p;
        logic signed [N-1:0] sa, sb;
        logic [N-1:0]        q, r;
        logic                s;
`ifdef MULDIV_SIGNED_EN
        s = sg;
`else
        s = sg & 1'b0;
`endif
        sa = a;
        sb = b;
        if (s) p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        else   p = {32'b0, a} * {32'b0, b};
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = '0;
        end else if (s) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        case (o)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10:   return q;
            default: return r;
        endcase
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            own_cnt = 0;
        end else begin
            if (alu_own) own_cnt++;
            if (done) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_done", 32'(done), 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("result", result, mon_e.res);
                    chk("done_edge", edge_cnt, mon_e.edge_no);
                    chk("own_cycles", own_cnt, mon_e.own);
                end
                own_cnt = 0;
            end
        end
    end

    // Called just after a rising edge with the DUT idle; returns likewise
    task automatic run_op(input logic [1:0] o, input logic sg, input logic [N-1:0] a,
                          input logic [N-1:0] b, input bit intr);
        exp_t e;
        bit   dbz;
        dbz       = o[1] && (b == 0);
        e.res     = model(o, sg, a, b);
        e.edge_no = edge_cnt + (dbz ? 1 : N + 1);
        e.own     = dbz ? 0 : N;
        sb_q.push_back(e);
        start = 1'b1; op = o; op_signed = sg; src_a = a; src_b = b;
        @(posedge clk); #1;
        start = 1'b0; src_a = ~a; src_b = b ^ 32'h5A5A_A5A5; op = ~o;
        chk("busy", 32'(busy), 32'd1);
        if (!dbz) chk("alu_ctrl", 32'(alu_ctrl), o[1] ? 32'd1 : 32'd0);
        if (intr) begin
            repeat (5) @(posedge clk);
            #1 start = 1'b1; op = 2'b10; src_a = 32'd9; src_b = 32'd3;
            @(posedge clk);
            #1 start = 1'b0;
        end
        for (int i = 0; i < 3 * N && sb_q.size() != 0; i++) @(posedge clk);
        if (sb_q.size() != 0) begin
            chk("timeout", sb_q.size(), 32'd0);
            sb_q.delete();
        end
        #1;
    endtask

    initial begin
        logic [1:0]   ro;
        logic         rs;
        logic [N-1:0] ra, rb;
        reset = 1'b1; start = 1'b0; op = 2'b00; op_signed = 1'b0; src_a = '0; src_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_own", 32'(alu_own), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op(2'b00, 1'b0, 32'h0000_1234, 32'h0000_5678, 1'b0);
        chk("mulu_small", result, 32'h0626_0060);
        run_op(2'b01, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("mulhu_max", result, 32'hFFFF_FFFE);
        run_op(2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("mulu_max", result, 32'h0000_0001);
        run_op(2'b10, 1'b0, 32'd100, 32'd7, 1'b0);
        chk("divu_100_7", result, 32'd14);
        run_op(2'b11, 1'b0, 32'd100, 32'd7, 1'b0);
        chk("remu_100_7", result, 32'd2);
        run_op(2'b10, 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
        chk("divu_hibit", result, 32'd1);
        run_op(2'b10, 1'b0, 32'h0000_1234, 32'd0, 1'b0);
        chk("divu_zero", result, 32'hFFFF_FFFF);
        run_op(2'b11, 1'b0, 32'h0000_1234, 32'd0, 1'b0);
        chk("remu_zero", result, 32'h0000_1234);

        run_op(2'b00, 1'b0, 32'h0001_2345, 32'h0000_0777, 1'b1);
        run_op(2'b11, 1'b0, 32'd1000, 32'd33, 1'b1);

        // Abort after ten iterations
        start = 1'b1; op = 2'b00; src_a = 32'h0000_DEAD; src_b = 32'h0000_BEEF;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_own", 32'(alu_own), 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_alu_a", alu_a, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        run_op(2'b10, 1'b0, 32'd1000000, 32'd3, 1'b0);
        chk("after_abort", result, 32'd333333);

        run_op(2'b10, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
`ifdef MULDIV_SIGNED_EN
        chk("sdiv_m7_2", result, 32'hFFFF_FFFD);
`endif
        run_op(2'b11, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
`ifdef MULDIV_SIGNED_EN
        chk("srem_m7_2", result, 32'hFFFF_FFFF);
`endif
        run_op(2'b10, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
`ifdef MULDIV_SIGNED_EN
        chk("sdiv_ovf", result, 32'h8000_0000);
`endif
        run_op(2'b11, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b01, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(2'b00, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFD, 1'b0);
        run_op(2'b10, 1'b1, 32'hFFFF_FFFB, 32'd0, 1'b0);
        run_op(2'b11, 1'b1, 32'hFFFF_FFFB, 32'd0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            run_op(ro, rs, ra, rb, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
